// File: rtl/exception_dispatcher_if.sv
// PSW write port and fetch-redirect handshake between the exception dispatcher
// and its consumers (PSW register, fetch stage).
`ifndef PSW_WRITE_DATA_SOURCE_WIDTH
`define PSW_WRITE_DATA_SOURCE_WIDTH        2
`define PSW_WRITE_DATA_SOURCE_NONE         2'd0
`define PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY 2'd1
`define PSW_WRITE_DATA_SOURCE_HANDLER_EXIT  2'd2
`endif

interface exception_dispatcher_if;
   logic                                    pswWriteEnable;
   logic [`PSW_WRITE_DATA_SOURCE_WIDTH-1:0] pswWriteDataSource;
   logic [4:0]                              priorityWriteValue;
   logic                                    handlerValid;
   logic [31:0]                             handlerAddress;
   logic                                    handlerAck;

   modport master (
      output pswWriteEnable,
      output pswWriteDataSource,
      output priorityWriteValue,
      output handlerValid,
      output handlerAddress,
      input  handlerAck
   );

   modport slave (
      input  pswWriteEnable,
      input  pswWriteDataSource,
      input  priorityWriteValue,
      input  handlerValid,
      input  handlerAddress,
      output handlerAck
   );
endinterface

// File: rtl/exception_dispatcher.sv
// Selects the winning interrupt/exception cause, drives the PSW entry/exit
// writes and hands the handler address to fetch via a valid/ack handshake.
`ifndef PSW_WRITE_DATA_SOURCE_WIDTH
`define PSW_WRITE_DATA_SOURCE_WIDTH        2
`define PSW_WRITE_DATA_SOURCE_NONE         2'd0
`define PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY 2'd1
`define PSW_WRITE_DATA_SOURCE_HANDLER_EXIT  2'd2
`endif

module exception_dispatcher #(
   parameter logic [31:0] VECTOR_BASE_ROM = 32'hE0000000,
   parameter logic [31:0] VECTOR_BASE_RAM = 32'hC0000000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [31:0]                 pswValue,
   input  logic [15:0]                 irqLines,
   input  logic                        instructionBoundary,
   input  logic                        exceptionRequest,
   input  logic [4:0]                  exceptionCode,
   input  logic                        exceptionIsUserTlbMiss,
   input  logic                        rfeRequest,
   exception_dispatcher_if.master      bus,
   output logic                        entryDone,
   output logic                        rfeDone,
   output logic                        busy
);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      ENTRY,
      REDIRECT,
      EXIT
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] cause_q, cause_d;
   logic [4:0] prio_q, prio_d;
   logic       tlb_q, tlb_d;
   logic       v_q, v_d;
   logic       entry_done_q, entry_done_d;

   logic [15:0] pending_irq;
   logic [4:0]  irq_cause;

   assign pending_irq = irqLines & pswValue[15:0] & {16{pswValue[23]}};

   // Ascending scan: the last hit is the highest pending index.
   always_comb begin
      irq_cause = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (pending_irq[i]) irq_cause = 5'(i);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cause_q      <= '0;
         prio_q       <= '0;
         tlb_q        <= 1'b0;
         v_q          <= 1'b0;
         entry_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         prio_q       <= prio_d;
         tlb_q        <= tlb_d;
         v_q          <= v_d;
         entry_done_q <= entry_done_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      cause_d                = cause_q;
      prio_d                 = prio_q;
      tlb_d                  = tlb_q;
      v_d                    = v_q;
      entry_done_d           = 1'b0;
      bus.pswWriteEnable     = 1'b0;
      bus.pswWriteDataSource = `PSW_WRITE_DATA_SOURCE_NONE;
      bus.handlerValid       = 1'b0;
      bus.handlerAddress     = '0;
      rfeDone                = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rfeRequest) begin
               state_d = EXIT;
            end else if (instructionBoundary && (exceptionRequest || (|pending_irq))) begin
               state_d = LATCH;
               cause_d = exceptionRequest ? exceptionCode : irq_cause;
               tlb_d   = exceptionRequest & exceptionIsUserTlbMiss;
               v_d     = pswValue[27];
            end
         end
         LATCH: begin
            // Priority output is registered so it holds after ENTRY.
            prio_d  = cause_q;
            state_d = ENTRY;
         end
         ENTRY: begin
            bus.pswWriteEnable     = 1'b1;
            bus.pswWriteDataSource = `PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY;
            state_d                = REDIRECT;
         end
         REDIRECT: begin
            bus.handlerValid   = 1'b1;
            bus.handlerAddress = (v_q ? VECTOR_BASE_ROM : VECTOR_BASE_RAM)
                               + (tlb_q ? 32'd0 : 32'd4);
            if (bus.handlerAck) begin
               entry_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         EXIT: begin
            bus.pswWriteEnable     = 1'b1;
            bus.pswWriteDataSource = `PSW_WRITE_DATA_SOURCE_HANDLER_EXIT;
            rfeDone                = 1'b1;
            state_d                = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.priorityWriteValue = prio_q;
   assign entryDone              = entry_done_q;
   assign busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_exception_dispatcher.sv
// Directed-vector bench for exception_dispatcher with hand-computed expectations.
`ifndef PSW_WRITE_DATA_SOURCE_WIDTH
`define PSW_WRITE_DATA_SOURCE_WIDTH        2
`define PSW_WRITE_DATA_SOURCE_NONE         2'd0
`define PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY 2'd1
`define PSW_WRITE_DATA_SOURCE_HANDLER_EXIT  2'd2
`endif

module tb_exception_dispatcher;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pswValue;
   logic [15:0] irqLines;
   logic        instructionBoundary;
   logic        exceptionRequest;
   logic [4:0]  exceptionCode;
   logic        exceptionIsUserTlbMiss;
   logic        rfeRequest;
   logic        entryDone;
   logic        rfeDone;
   logic        busy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   exception_dispatcher_if bus_if ();

   exception_dispatcher #(
      .VECTOR_BASE_ROM (32'hE0000000),
      .VECTOR_BASE_RAM (32'hC0000000)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .pswValue               (pswValue),
      .irqLines               (irqLines),
      .instructionBoundary    (instructionBoundary),
      .exceptionRequest       (exceptionRequest),
      .exceptionCode          (exceptionCode),
      .exceptionIsUserTlbMiss (exceptionIsUserTlbMiss),
      .rfeRequest             (rfeRequest),
      .bus                    (bus_if.master),
      .entryDone              (entryDone),
      .rfeDone                (rfeDone),
      .busy                   (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      pswValue = '0;
      irqLines = '0;
      instructionBoundary = 1'b0;
      exceptionRequest = 1'b0;
      exceptionCode = '0;
      exceptionIsUserTlbMiss = 1'b0;
      rfeRequest = 1'b0;
      bus_if.handlerAck = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_we",    32'(bus_if.pswWriteEnable), 32'd0);
      check("rst_valid", 32'(bus_if.handlerValid),   32'd0);
      check("rst_busy",  32'(busy),                  32'd0);
      check("rst_prio",  32'(bus_if.priorityWriteValue), 32'd0);
      check("rst_done",  32'(entryDone),             32'd0);
      check("rst_rfe",   32'(rfeDone),               32'd0);
      check("rst_addr",  bus_if.handlerAddress,      32'd0);

      // Reset while presenting a handler address
      pswValue = 32'h0080_00FF;
      irqLines = 16'h0024;
      instructionBoundary = 1'b1;
      tick();
      instructionBoundary = 1'b0;
      tick();
      tick();
      check("t1_valid_pre", 32'(bus_if.handlerValid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t1_valid", 32'(bus_if.handlerValid),   32'd0);
      check("t1_busy",  32'(busy),                  32'd0);
      check("t1_we",    32'(bus_if.pswWriteEnable), 32'd0);
      check("t1_prio",  32'(bus_if.priorityWriteValue), 32'd0);
      tick();
      check("t1_idle",  32'(busy),                  32'd0);

      // IRQ 5 wins over IRQ 2, RAM vector, stalled ack
      instructionBoundary = 1'b1;
      tick();
      instructionBoundary = 1'b0;
      check("t2_latch_busy", 32'(busy), 32'd1);
      check("t2_latch_we",   32'(bus_if.pswWriteEnable), 32'd0);
      tick();
      check("t2_we",   32'(bus_if.pswWriteEnable), 32'd1);
      check("t2_src",  32'(bus_if.pswWriteDataSource), 32'(`PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY));
      check("t2_prio", 32'(bus_if.priorityWriteValue), 32'd5);
      check("t2_valid_entry", 32'(bus_if.handlerValid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_valid", 32'(bus_if.handlerValid), 32'd1);
         check("t2_addr",  bus_if.handlerAddress,    32'hC000_0004);
         check("t2_done_stall", 32'(entryDone),      32'd0);
      end
      bus_if.handlerAck = 1'b1;
      tick();
      bus_if.handlerAck = 1'b0;
      irqLines = '0;
      check("t2_done",  32'(entryDone), 32'd1);
      check("t2_valid_off", 32'(bus_if.handlerValid), 32'd0);
      check("t2_busy",  32'(busy), 32'd0);
      tick();
      check("t2_done_pulse", 32'(entryDone), 32'd0);
      check("t2_prio_hold",  32'(bus_if.priorityWriteValue), 32'd5);

      // Stray ack while idle is ignored
      bus_if.handlerAck = 1'b1;
      tick();
      bus_if.handlerAck = 1'b0;
      check("ack_idle_done", 32'(entryDone), 32'd0);
      check("ack_idle_busy", 32'(busy), 32'd0);

      // IE=0 masks everything; exception still enters
      pswValue = 32'h0000_FFFF;
      irqLines = 16'hFFFF;
      instructionBoundary = 1'b1;
      tick();
      check("t3_masked_busy", 32'(busy), 32'd0);
      tick();
      check("t3_masked_we", 32'(bus_if.pswWriteEnable), 32'd0);
      exceptionRequest = 1'b1;
      exceptionCode = 5'd16;
      tick();
      instructionBoundary = 1'b0;
      check("t3_busy", 32'(busy), 32'd1);
      tick();
      check("t3_we",   32'(bus_if.pswWriteEnable), 32'd1);
      check("t3_prio", 32'(bus_if.priorityWriteValue), 32'd16);
      tick();
      check("t3_addr", bus_if.handlerAddress, 32'hC000_0004);
      bus_if.handlerAck = 1'b1;
      tick();
      bus_if.handlerAck = 1'b0;
      check("t3_done", 32'(entryDone), 32'd1);
      exceptionRequest = 1'b0;
      irqLines = '0;
      tick();

      // Exception beats IRQ 15, user TLB miss, V=1 sampled before PSW changes
      pswValue = 32'h0880_FFFF;
      irqLines = 16'h8000;
      exceptionRequest = 1'b1;
      exceptionCode = 5'd21;
      exceptionIsUserTlbMiss = 1'b1;
      instructionBoundary = 1'b1;
      tick();
      instructionBoundary = 1'b0;
      pswValue = 32'h0080_FFFF;
      tick();
      check("t4_prio", 32'(bus_if.priorityWriteValue), 32'd21);
      check("t4_src",  32'(bus_if.pswWriteDataSource), 32'(`PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY));
      tick();
      check("t4_valid", 32'(bus_if.handlerValid), 32'd1);
      check("t4_addr",  bus_if.handlerAddress, 32'hE000_0000);
      bus_if.handlerAck = 1'b1;
      tick();
      bus_if.handlerAck = 1'b0;
      check("t4_done", 32'(entryDone), 32'd1);
      exceptionRequest = 1'b0;
      exceptionIsUserTlbMiss = 1'b0;
      irqLines = '0;
      tick();

      // RFE takes precedence over a simultaneous entry
      pswValue = 32'h0080_00FF;
      irqLines = 16'h0024;
      instructionBoundary = 1'b1;
      rfeRequest = 1'b1;
      tick();
      rfeRequest = 1'b0;
      instructionBoundary = 1'b0;
      check("t5_we",   32'(bus_if.pswWriteEnable), 32'd1);
      check("t5_src",  32'(bus_if.pswWriteDataSource), 32'(`PSW_WRITE_DATA_SOURCE_HANDLER_EXIT));
      check("t5_rfe",  32'(rfeDone), 32'd1);
      check("t5_busy", 32'(busy), 32'd1);
      check("t5_valid", 32'(bus_if.handlerValid), 32'd0);
      tick();
      check("t5_idle",    32'(busy), 32'd0);
      check("t5_rfe_off", 32'(rfeDone), 32'd0);
      check("t5_we_off",  32'(bus_if.pswWriteEnable), 32'd0);
      instructionBoundary = 1'b1;
      tick();
      instructionBoundary = 1'b0;
      check("t5_latch", 32'(busy), 32'd1);
      tick();
      check("t5_prio", 32'(bus_if.priorityWriteValue), 32'd5);
      check("t5_entry_src", 32'(bus_if.pswWriteDataSource), 32'(`PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY));
      tick();
      bus_if.handlerAck = 1'b1;
      tick();
      bus_if.handlerAck = 1'b0;
      check("t5_done", 32'(entryDone), 32'd1);
      irqLines = '0;
      tick();

      // IRQ dropped before boundary, then latched cause ignores a later IRQ
      pswValue = 32'h0080_FFFF;
      irqLines = 16'h0008;
      tick();
      irqLines = 16'h0000;
      instructionBoundary = 1'b1;
      tick();
      instructionBoundary = 1'b0;
      check("t6_drop_busy", 32'(busy), 32'd0);
      tick();
      check("t6_drop_we", 32'(bus_if.pswWriteEnable), 32'd0);
      irqLines = 16'h0008;
      instructionBoundary = 1'b1;
      tick();
      instructionBoundary = 1'b0;
      irqLines = 16'h0208;
      check("t6_latch", 32'(busy), 32'd1);
      tick();
      check("t6_prio", 32'(bus_if.priorityWriteValue), 32'd3);
      tick();
      check("t6_addr", bus_if.handlerAddress, 32'hC000_0004);
      bus_if.handlerAck = 1'b1;
      tick();
      bus_if.handlerAck = 1'b0;
      irqLines = '0;
      check("t6_done", 32'(entryDone), 32'd1);
      tick();
      check("t6_end_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/exception_dispatcher.md
Name: exception_dispatcher

Overview:
- Decides when the CPU enters an interrupt or exception handler, and drives the PSW write port to apply the handler-entry and handler-exit transformations.
- Reads the current PSW value, the 16 external IRQ lines and synchronous exception requests from the pipeline.
- Selects the winning cause, supplies the new priority to the PSW and hands the handler address to the fetch stage through a valid/ack handshake.
- Sits between the pipeline control unit and the ProcessorStatusWord register.

Parameters:
- VECTOR_BASE_ROM, 32'hE0000000, handler base address when PSW vector bit V=1.
- VECTOR_BASE_RAM, 32'hC0000000, handler base address when V=0.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pswValue  in  32  current PSW read value. Fields: [27] V, [23] IE, [15:0] interrupt mask.
- irqLines  in  16  level-sensitive external interrupt requests.
- instructionBoundary  in  1  pipeline is at an instruction boundary; entry may start.
- exceptionRequest  in  1  synchronous exception pending; held high until entryDone.
- exceptionCode  in  5  exception cause, 16..31.
- exceptionIsUserTlbMiss  in  1  the pending exception is a user-space TLB miss.
- rfeRequest  in  1  one-cycle pulse: execute return-from-exception.
- pswWriteEnable  out  1  PSW write strobe.
- pswWriteDataSource  out  `PSW_WRITE_DATA_SOURCE_WIDTH  selects HANDLER_ENTRY or HANDLER_EXIT.
- priorityWriteValue  out  5  winning cause number, written into PSW[20:16] on entry.
- handlerValid  out  1  handlerAddress is valid.
- handlerAddress  out  32  handler start address.
- handlerAck  in  1  fetch stage accepted the address.
- entryDone  out  1  one-cycle pulse when entry completes.
- rfeDone  out  1  one-cycle pulse when the exit write has been issued.
- busy  out  1  FSM is not IDLE.

Behaviour:
- Reset: all outputs are 0; state=IDLE; latched cause=0. A reset in any state returns to IDLE on the same edge. Any partial PSW write already strobed is not undone.
- pendingIrq = irqLines & pswValue[15:0] & {16{pswValue[23]}}, combinational.
- Cause selection:
  - exceptionRequest has priority over all interrupts; cause = exceptionCode.
  - Otherwise cause = the highest index i with pendingIrq[i]=1.
  - No request means no entry.
- IDLE transitions:
  - rfeRequest=1 -> EXIT. rfeRequest has priority over a simultaneous entry condition; the entry is re-evaluated afterwards.
  - Else instructionBoundary=1 and (exceptionRequest or |pendingIrq) -> LATCH. Cause and user-TLB flag are registered; V is registered from pswValue[27].
- LATCH (1 cycle) -> ENTRY.
- ENTRY (1 cycle):
  - pswWriteEnable=1, pswWriteDataSource=`PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY, priorityWriteValue=latched cause.
  - Next state is REDIRECT.
- REDIRECT:
  - handlerValid=1.
  - handlerAddress = (latched V ? VECTOR_BASE_ROM : VECTOR_BASE_RAM) + (userTlbMiss ? 0 : 4).
  - Address and valid are held stable until handlerAck=1. On the ack edge: entryDone pulses for 1 cycle, next state is IDLE.
  - handlerAck while handlerValid=0 is ignored.
- EXIT (1 cycle):
  - pswWriteEnable=1, pswWriteDataSource=`PSW_WRITE_DATA_SOURCE_HANDLER_EXIT.
  - rfeDone pulses, next state is IDLE.
- rfeRequest outside IDLE is ignored; the pipeline must not issue it.
- IRQ changes after LATCH do not affect the latched cause. An IRQ dropping before LATCH causes no entry.
- V is sampled before the PSW entry write, so the vector address uses the pre-entry V. The entry transform preserves V.
- Latency: boundary-with-request to the PSW write strobe is 2 cycles. Boundary to handlerValid is 3 cycles.
- priorityWriteValue holds its last value outside ENTRY; it is 0 after reset.
- busy=1 in LATCH, ENTRY, REDIRECT and EXIT.

Test Plan:
1. Reset mid-REDIRECT: assert reset for 1 cycle -> next cycle handlerValid=0, busy=0, pswWriteEnable=0.
2. PSW=32'h0080_00FF, irqLines=16'h0024, boundary -> ENTRY with priorityWriteValue=5, HANDLER_ENTRY source. handlerAddress=32'hC0000004 held over 3 stall cycles until ack; then entryDone=1 for 1 cycle.
3. PSW IE=0, irqLines=16'hFFFF, boundary -> no entry, busy stays 0. Same stimulus with exceptionRequest=1, code=16 -> entry, priority=16.
4. PSW=32'h0880_FFFF, IRQ 15 pending, exceptionRequest=1, code=21, exceptionIsUserTlbMiss=1 -> priority=21, handlerAddress=32'hE0000000.
5. rfeRequest and boundary-with-IRQ in the same IDLE cycle -> EXIT write with HANDLER_EXIT source and rfeDone. The next cycle is IDLE, and entry starts on the next boundary.
6. IRQ 3 asserted then dropped before boundary -> no entry. IRQ 3 held and IRQ 9 raised in LATCH -> priority=3.
